mem_port_arbiter: RTL and testbench

- Shares one single-ported 32-bit unified memory between the instruction-fetch requester and the load/store requester of the 3-stage pipeline.
- Sequences each access as a request/acknowledge transaction with a multi-cycle memory.
- Generates byte-lane write masks and aligned write data from fun3.
- Sign- or zero-extends load data from fun3.
- Provides a stall signal to the pipeline.

---
 rtl/mem_port_arbiter_pkg.sv | 26 ++
 rtl/mem_lane_align.sv | 61 ++++++
 rtl/mem_port_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory port arbiter: access sizes, FSM states,
// grant identifiers and the instruction returned on a failed fetch.
package mem_port_arbiter_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // addi x0, x0, 0 : harmless filler when a fetch times out
   localparam logic [31:0] NOP_INSN = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_IF_BUSY = 2'd1,
      S_DM_BUSY = 2'd2,
      S_RESP    = 2'd3
   } state_t;

   typedef enum logic {
      GNT_IF = 1'b0,
      GNT_DM = 1'b1
   } grant_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between a 32-bit memory word and right-justified
// requester data. Purely combinational; store and load sides are independent
// so the top can drive them from live and captured request fields.
module mem_lane_align
   import mem_port_arbiter_pkg::*;
(
   input  logic [2:0]  st_fun3,
   input  logic [1:0]  st_off,
   input  logic [31:0] st_data,
   output logic [3:0]  st_mask,
   output logic [31:0] st_aligned,
   output logic        misalign,
   input  logic [2:0]  ld_fun3,
   input  logic [1:0]  ld_off,
   input  logic [31:0] ld_raw,
   output logic [31:0] ld_ext
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   // Store side: replicate the datum to every lane it could land in and let
   // the mask pick the lane; unsupported sizes are flagged like misalignment.
   always_comb begin
      st_mask    = 4'b0000;
      st_aligned = st_data;
      misalign   = 1'b0;
      case (st_fun3)
         F3_B, F3_BU: begin
            st_mask    = 4'b0001 << st_off;
            st_aligned = {4{st_data[7:0]}};
         end
         F3_H, F3_HU: begin
            st_mask    = 4'b0011 << st_off;
            st_aligned = {2{st_data[15:0]}};
            misalign   = st_off[0];
         end
         F3_W: begin
            st_mask  = 4'b1111;
            misalign = |st_off;
         end
         default: misalign = 1'b1;
      endcase
   end

   // Load side: pick the addressed byte/half, then sign- or zero-extend.
   always_comb begin
      ld_byte = ld_raw[{ld_off, 3'b000} +: 8];
      ld_half = ld_off[1] ? ld_raw[31:16] : ld_raw[15:0];
      ld_ext  = 32'h0;
      case (ld_fun3)
         F3_B:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
         F3_BU:   ld_ext = {24'h0, ld_byte};
         F3_H:    ld_ext = {{16{ld_half[15]}}, ld_half};
         F3_HU:   ld_ext = {16'h0, ld_half};
         F3_W:    ld_ext = ld_raw;
         default: ld_ext = 32'h0;
      endcase
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store.
// Alternating-priority arbitration, req/ack sequencing with a timeout, and
// registered one-cycle responses back to each requester.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_valid,
   output logic [31:0]       if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [2:0]        dm_fun3,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [31:0]       dm_wdata,
   output logic              dm_valid,
   output logic [31:0]       dm_rdata,
   output logic              dm_err,
   output logic              stall,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-3:0] mem_addr,
   output logic [3:0]        mem_mask,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata
);

   localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

   state_t           state, state_nxt;
   grant_t           last_grant;
   logic [CNT_W-1:0] cnt;
   logic             grant_if, grant_dm, fin_ok, fin_to;

   // load attributes captured at issue so the response does not depend on
   // the requester keeping its inputs steady
   logic [2:0]       ld_fun3;
   logic [1:0]       ld_off;
   logic             ld_we;

   logic [3:0]       st_mask;
   logic [31:0]      st_aligned, ld_ext;
   logic             st_misalign;

   // fetches are word-aligned by contract; the low bits carry nothing
   logic             unused_if_off;
   assign unused_if_off = ^if_addr[1:0];

   mem_lane_align u_align (
      .st_fun3    (dm_fun3),
      .st_off     (dm_addr[1:0]),
      .st_data    (dm_wdata),
      .st_mask    (st_mask),
      .st_aligned (st_aligned),
      .misalign   (st_misalign),
      .ld_fun3    (ld_fun3),
      .ld_off     (ld_off),
      .ld_raw     (mem_rdata),
      .ld_ext     (ld_ext)
   );

   assign stall = (if_req & ~if_valid) | (dm_req & ~dm_valid);

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // Next state, arbitration and completion decode
   always_comb begin
      state_nxt = state;
      grant_if  = 1'b0;
      grant_dm  = 1'b0;
      fin_ok    = 1'b0;
      fin_to    = 1'b0;
      case (state)
         S_IDLE: begin
            if (if_req && (!dm_req || last_grant == GNT_DM)) begin
               grant_if  = 1'b1;
               state_nxt = S_IF_BUSY;
            end else if (dm_req) begin
               grant_dm  = 1'b1;
               state_nxt = st_misalign ? S_RESP : S_DM_BUSY;
            end
         end
         S_IF_BUSY, S_DM_BUSY: begin
            if (mem_ack) begin
               fin_ok    = 1'b1;
               state_nxt = S_RESP;
            end else if (cnt == CNT_W'(TIMEOUT)) begin
               fin_to    = 1'b1;
               state_nxt = S_RESP;
            end
         end
         S_RESP:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Memory-side and response-side registers, counter and grant history
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_grant <= GNT_DM;
         cnt        <= '0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_mask   <= 4'b0000;
         mem_wdata  <= 32'h0;
         ld_fun3    <= 3'b000;
         ld_off     <= 2'b00;
         ld_we      <= 1'b0;
         if_valid   <= 1'b0;
         if_rdata   <= 32'h0;
         dm_valid   <= 1'b0;
         dm_rdata   <= 32'h0;
         dm_err     <= 1'b0;
      end else begin
         if_valid <= 1'b0;
         dm_valid <= 1'b0;
         dm_err   <= 1'b0;
         case (state)
            S_IDLE: begin
               cnt <= '0;
               if (grant_if) begin
                  last_grant <= GNT_IF;
                  mem_req    <= 1'b1;
                  mem_we     <= 1'b0;
                  mem_addr   <= if_addr[ADDR_W-1:2];
                  mem_mask   <= 4'b0000;
                  mem_wdata  <= 32'h0;
               end else if (grant_dm) begin
                  last_grant <= GNT_DM;
                  if (st_misalign) begin
                     dm_valid <= 1'b1;
                     dm_err   <= 1'b1;
                     dm_rdata <= 32'h0;
                  end else begin
                     mem_req   <= 1'b1;
                     mem_we    <= dm_we;
                     mem_addr  <= dm_addr[ADDR_W-1:2];
                     mem_mask  <= dm_we ? st_mask : 4'b0000;
                     mem_wdata <= dm_we ? st_aligned : 32'h0;
                     ld_fun3   <= dm_fun3;
                     ld_off    <= dm_addr[1:0];
                     ld_we     <= dm_we;
                  end
               end
            end
            S_IF_BUSY, S_DM_BUSY: begin
               if (fin_ok || fin_to) begin
                  cnt       <= '0;
                  mem_req   <= 1'b0;
                  mem_we    <= 1'b0;
                  mem_mask  <= 4'b0000;
                  mem_wdata <= 32'h0;
                  if (state == S_IF_BUSY) begin
                     if_valid <= 1'b1;
                     if_rdata <= fin_ok ? mem_rdata : NOP_INSN;
                  end else begin
                     dm_valid <= 1'b1;
                     dm_err   <= fin_to;
                     dm_rdata <= (fin_ok && !ld_we) ? ld_ext : 32'h0;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: cnt <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, contention, store lanes,
// load extension, misalignment, timeout and asynchronous reset abort.
module tb_mem_port_arbiter;

   localparam int ADDR_W  = 32;
   localparam int TIMEOUT = 15;

   logic              clk, rst;
   logic              if_req, if_valid;
   logic [ADDR_W-1:0] if_addr, dm_addr;
   logic [31:0]       if_rdata, dm_wdata, dm_rdata, mem_wdata, mem_rdata;
   logic              dm_req, dm_we, dm_valid, dm_err, stall;
   logic [2:0]        dm_fun3;
   logic              mem_req, mem_we, mem_ack;
   logic [ADDR_W-3:0] mem_addr;
   logic [3:0]        mem_mask;

   int vectors     = 0;
   int miscompares = 0;

   mem_port_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_fun3(dm_fun3), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_valid(dm_valid), .dm_rdata(dm_rdata), .dm_err(dm_err),
      .stall(stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_mask(mem_mask),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] exp);
      dm_req = 1'b1; dm_we = 1'b0; dm_fun3 = f3; dm_addr = a; mem_ack = 1'b1;
      tick();
      chk({tag, "_mask"}, {28'h0, mem_mask}, 32'h0);
      tick();
      chk({tag, "_valid"}, {31'h0, dm_valid}, 32'h1);
      chk(tag, dm_rdata, exp);
      dm_req = 1'b0; mem_ack = 1'b0;
      tick();
   endtask

   initial begin
      rst = 1'b0; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
      dm_fun3 = 3'b000; dm_addr = '0; dm_wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;

      // reset state
      tick(); tick();
      chk("rst_mem_req",  {31'h0, mem_req},  32'h0);
      chk("rst_if_valid", {31'h0, if_valid}, 32'h0);
      chk("rst_dm_valid", {31'h0, dm_valid}, 32'h0);
      chk("rst_stall",    {31'h0, stall},    32'h0);
      rst = 1'b1;

      // fetch, memory acks on the third busy cycle -> if_valid after edge 4
      if_req = 1'b1; if_addr = 32'h100;
      #1 chk("f_stall_req", {31'h0, stall}, 32'h1);
      tick();
      chk("f_mem_req",  {31'h0, mem_req}, 32'h1);
      chk("f_mem_addr", {2'b0, mem_addr}, 32'h40);
      chk("f_mem_we",   {31'h0, mem_we},  32'h0);
      chk("f_mem_mask", {28'h0, mem_mask}, 32'h0);
      tick();
      chk("f_wait_stall", {31'h0, stall}, 32'h1);
      tick();
      chk("f_wait_valid", {31'h0, if_valid}, 32'h0);
      mem_ack = 1'b1; mem_rdata = 32'h0050_0093;
      tick();
      chk("f_valid",   {31'h0, if_valid}, 32'h1);
      chk("f_rdata",   if_rdata, 32'h0050_0093);
      chk("f_stall",   {31'h0, stall},   32'h0);
      chk("f_req_off", {31'h0, mem_req}, 32'h0);
      if_req = 1'b0; mem_ack = 1'b0;
      tick();
      chk("f_pulse", {31'h0, if_valid}, 32'h0);

      // contention from reset: if first, then strict alternation
      rst = 1'b0; #1 rst = 1'b1;
      if_req = 1'b1; if_addr = 32'h10;
      dm_req = 1'b1; dm_we = 1'b0; dm_fun3 = 3'b010; dm_addr = 32'h200;
      mem_ack = 1'b1;
      for (int i = 0; i < 4; i++) begin
         mem_rdata = 32'h1000_0000 + i;
         tick();
         chk("c_if_addr", {2'b0, mem_addr}, 32'h4);
         tick();
         chk("c_if_valid", {31'h0, if_valid}, 32'h1);
         chk("c_if_rdata", if_rdata, 32'h1000_0000 + i);
         chk("c_dm_wait",  {31'h0, dm_valid}, 32'h0);
         tick();
         tick();
         chk("c_dm_addr", {2'b0, mem_addr}, 32'h80);
         tick();
         chk("c_dm_valid", {31'h0, dm_valid}, 32'h1);
         chk("c_dm_rdata", dm_rdata, 32'h1000_0000 + i);
         tick();
      end
      if_req = 1'b0; dm_req = 1'b0; mem_ack = 1'b0;
      tick();

      // store byte at offset 3
      dm_req = 1'b1; dm_we = 1'b1; dm_fun3 = 3'b000; dm_addr = 32'h203; dm_wdata = 32'hA5;
      tick();
      chk("sb_we",    {31'h0, mem_we},   32'h1);
      chk("sb_mask",  {28'h0, mem_mask}, 32'h8);
      chk("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
      chk("sb_addr",  {2'b0, mem_addr}, 32'h80);
      mem_ack = 1'b1;
      tick();
      chk("sb_valid", {31'h0, dm_valid}, 32'h1);
      chk("sb_rdata", dm_rdata, 32'h0);
      chk("sb_err",   {31'h0, dm_err}, 32'h0);
      dm_req = 1'b0; mem_ack = 1'b0;
      tick();

      // store half at offset 2
      dm_req = 1'b1; dm_we = 1'b1; dm_fun3 = 3'b001; dm_addr = 32'h202; dm_wdata = 32'hFFFF_1234;
      tick();
      chk("sh_mask",  {28'h0, mem_mask}, 32'hC);
      chk("sh_wdata", mem_wdata, 32'h1234_1234);
      mem_ack = 1'b1;
      tick();
      dm_req = 1'b0; mem_ack = 1'b0;
      tick();

      // load extension
      mem_rdata = 32'h80F0_7F81;
      do_load("lh2",  3'b001, 32'h202, 32'hFFFF_80F0);
      do_load("lhu2", 3'b101, 32'h202, 32'h0000_80F0);
      do_load("lb0",  3'b000, 32'h200, 32'hFFFF_FF81);
      do_load("lbu1", 3'b100, 32'h201, 32'h0000_007F);

      // misaligned word and unsupported size: immediate error response
      dm_req = 1'b1; dm_we = 1'b0; dm_fun3 = 3'b010; dm_addr = 32'h202;
      tick();
      chk("mis_mem_req", {31'h0, mem_req},  32'h0);
      chk("mis_valid",   {31'h0, dm_valid}, 32'h1);
      chk("mis_err",     {31'h0, dm_err},   32'h1);
      chk("mis_rdata",   dm_rdata, 32'h0);
      dm_req = 1'b0;
      tick();
      dm_req = 1'b1; dm_fun3 = 3'b011; dm_addr = 32'h200;
      tick();
      chk("bad_f3_err", {31'h0, dm_err}, 32'h1);
      dm_req = 1'b0;
      tick();

      // fetch timeout: no ack -> NOP after TIMEOUT+2 edges
      if_req = 1'b1; if_addr = 32'h44;
      repeat (TIMEOUT + 1) tick();
      chk("to_req_held", {31'h0, mem_req},  32'h1);
      chk("to_no_valid", {31'h0, if_valid}, 32'h0);
      tick();
      chk("to_valid",   {31'h0, if_valid}, 32'h1);
      chk("to_nop",     if_rdata, 32'h0000_0013);
      chk("to_req_off", {31'h0, mem_req}, 32'h0);
      if_req = 1'b0;
      tick();

      // async reset during DM_BUSY, then a pending fetch is served
      dm_req = 1'b1; dm_we = 1'b1; dm_fun3 = 3'b010; dm_addr = 32'h200; dm_wdata = 32'h1;
      tick();
      chk("ra_busy_req", {31'h0, mem_req}, 32'h1);
      #2 rst = 1'b0;
      #1;
      chk("ra_mem_req",  {31'h0, mem_req},  32'h0);
      chk("ra_mem_we",   {31'h0, mem_we},   32'h0);
      chk("ra_mem_mask", {28'h0, mem_mask}, 32'h0);
      dm_req = 1'b0; if_req = 1'b1; if_addr = 32'h8;
      tick();
      rst = 1'b1;
      tick();
      chk("ra_if_req",  {31'h0, mem_req}, 32'h1);
      chk("ra_if_addr", {2'b0, mem_addr}, 32'h2);
      mem_ack = 1'b1; mem_rdata = 32'hCAFE_0001;
      tick();
      chk("ra_if_valid", {31'h0, if_valid}, 32'h1);
      chk("ra_if_rdata", if_rdata, 32'hCAFE_0001);
      if_req = 1'b0; mem_ack = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
